// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage
// and the pipeline registers built from if_id_register.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id.sv
// Generic pipeline register: instruction, PC+4 and valid.
// Flush beats hold, hold beats load; otherwise contents are kept.
module if_id_register
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic                   i_hold,
    input  logic                   i_flush,
    input  logic [INSTR_WIDTH-1:0] i_Instruction,
    input  logic [ADDR_WIDTH-1:0]  i_PC_Plus_4,
    output logic [INSTR_WIDTH-1:0] o_Instruction,
    output logic [ADDR_WIDTH-1:0]  o_PC_Plus_4,
    output logic                   o_Sig_Valid
);

    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_pc_plus_4;
    logic                   r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr     <= '0;
            r_pc_plus_4 <= '0;
            r_valid     <= 1'b0;
        end else if (i_flush) begin
            r_instr <= INSTR_WIDTH'(BUBBLE_INSTR);
            r_valid <= 1'b0;
        end else if (i_load && !i_hold) begin
            r_instr     <= i_Instruction;
            r_pc_plus_4 <= i_PC_Plus_4;
            r_valid     <= 1'b1;
        end
    end

    assign o_Instruction = r_instr;
    assign o_PC_Plus_4   = r_pc_plus_4;
    assign o_Sig_Valid   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, skid buffer for stalls,
// drain of orphaned requests after a branch, and the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_Sig_Hazard_Detected,
    input  logic                   i_Sig_Branch_Taken,
    input  logic [ADDR_WIDTH-1:0]  i_Branch_Address,
    output logic [ADDR_WIDTH-1:0]  o_Imem_Address,
    output logic                   o_Sig_Imem_Read_Enable,
    input  logic [INSTR_WIDTH-1:0] i_Imem_Data,
    input  logic                   i_Sig_Imem_Ready,
    output logic [INSTR_WIDTH-1:0] o_Instruction,
    output logic [ADDR_WIDTH-1:0]  o_PC_Plus_4,
    output logic                   o_Sig_Valid
);

    fetch_state_e           r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [INSTR_WIDTH-1:0] r_skid;
    logic [ADDR_WIDTH-1:0]  r_pending;

    fetch_state_e           w_next_state;
    logic [ADDR_WIDTH-1:0]  w_next_pc;
    logic [INSTR_WIDTH-1:0] w_next_skid;
    logic [ADDR_WIDTH-1:0]  w_next_pending;
    logic [ADDR_WIDTH-1:0]  w_pc_plus_4;
    logic [INSTR_WIDTH-1:0] w_load_instr;
    logic                   w_req;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_flush;

    // Request depends on registered state only, never on ready.
    assign w_req       = (r_state != HOLD);
    assign w_accept    = w_req && i_Sig_Imem_Ready;
    assign w_pc_plus_4 = r_pc + ADDR_WIDTH'(INSTR_BYTES);

    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_skid    = r_skid;
        w_next_pending = r_pending;
        w_load_instr   = i_Imem_Data;
        w_load         = 1'b0;
        w_flush        = 1'b0;
        unique case (r_state)
            FETCH: begin
                if (i_Sig_Branch_Taken) begin
                    w_flush = 1'b1;
                    if (w_accept) begin
                        w_next_pc = i_Branch_Address;
                    end else begin
                        w_next_pending = i_Branch_Address;
                        w_next_state   = DRAIN;
                    end
                end else if (w_accept && !i_Sig_Hazard_Detected) begin
                    w_load    = 1'b1;
                    w_next_pc = w_pc_plus_4;
                end else if (w_accept) begin
                    w_next_skid  = i_Imem_Data;
                    w_next_state = HOLD;
                end else if (!i_Sig_Hazard_Detected) begin
                    // Nothing arrived and decode is free: insert a bubble.
                    w_flush = 1'b1;
                end
            end
            HOLD: begin
                w_load_instr = r_skid;
                if (i_Sig_Branch_Taken) begin
                    w_flush      = 1'b1;
                    w_next_pc    = i_Branch_Address;
                    w_next_skid  = '0;
                    w_next_state = FETCH;
                end else if (!i_Sig_Hazard_Detected) begin
                    w_load       = 1'b1;
                    w_next_pc    = w_pc_plus_4;
                    w_next_state = FETCH;
                end
            end
            DRAIN: begin
                if (i_Sig_Branch_Taken) begin
                    w_next_pending = i_Branch_Address;
                end
                if (i_Sig_Branch_Taken || !i_Sig_Hazard_Detected) begin
                    w_flush = 1'b1;
                end
                // Last branch wins even when it lands with the accept.
                if (w_accept) begin
                    w_next_pc    = i_Sig_Branch_Taken ? i_Branch_Address
                                                      : r_pending;
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_skid    <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pc      <= w_next_pc;
            r_skid    <= w_next_skid;
            r_pending <= w_next_pending;
        end
    end

    assign o_Imem_Address         = r_pc;
    assign o_Sig_Imem_Read_Enable = w_req;

    if_id_register #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_hold        (i_Sig_Hazard_Detected),
        .i_flush       (w_flush),
        .i_Instruction (w_load_instr),
        .i_PC_Plus_4   (w_pc_plus_4),
        .o_Instruction (o_Instruction),
        .o_PC_Plus_4   (o_PC_Plus_4),
        .o_Sig_Valid   (o_Sig_Valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/branch/ready
// traffic, compared against a transaction-level model of the fetch stage.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_br = 1'b0;
    logic [31:0] i_tgt = '0;
    logic [31:0] o_addr;
    logic        o_req;
    logic [31:0] i_data;
    logic        i_rdy = 1'b1;
    logic [31:0] o_instr;
    logic [31:0] o_pc4;
    logic        o_valid;

    int n_checks = 0;
    int n_fail = 0;

    // Memory returns the word address as the instruction.
    assign i_data = o_addr;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .i_Sig_Hazard_Detected  (i_stall),
        .i_Sig_Branch_Taken     (i_br),
        .i_Branch_Address       (i_tgt),
        .o_Imem_Address         (o_addr),
        .o_Sig_Imem_Read_Enable (o_req),
        .i_Imem_Data            (i_data),
        .i_Sig_Imem_Ready       (i_rdy),
        .o_Instruction          (o_instr),
        .o_PC_Plus_4            (o_pc4),
        .o_Sig_Valid            (o_valid)
    );

    // Reference model: next address to fetch, a parked word waiting for
    // decode, an abandoned request still in flight, and the IF/ID contents.
    logic [31:0] m_pc;
    bit          m_parked;
    logic [31:0] m_parked_word;
    bit          m_orphan;
    logic [31:0] m_redirect;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_parked = 1'b0;
        m_parked_word = '0;
        m_orphan = 1'b0;
        m_redirect = '0;
        m_instr = '0;
        m_pc4 = '0;
        m_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_stall = 1'b0;
        i_br = 1'b0;
        i_rdy = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_valid", 64'(o_valid), 64'(0));
        check_eq("rst_instr", 64'(o_instr), 64'(0));
        check_eq("rst_pc4", 64'(o_pc4), 64'(0));
        check_eq("rst_addr", 64'(o_addr), 64'(0));
        check_eq("rst_req", 64'(o_req), 64'(1));
        check_eq("rst_state", 64'(dut.r_state), 64'(FETCH));
    endtask

    task automatic step(input bit st, input bit br, input logic [31:0] tgt,
                        input bit rdy);
        bit          acc;
        logic [31:0] word;
        @(negedge clk);
        reset = 1'b0;
        i_stall = st;
        i_br = br;
        i_tgt = tgt;
        i_rdy = rdy;
        #1;
        check_eq("req", 64'(o_req), 64'(!m_parked));
        check_eq("addr", 64'(o_addr), 64'(m_pc));
        acc = rdy && !m_parked;
        word = m_pc;
        if (br) begin
            m_valid = 1'b0;
            m_instr = '0;
            if (m_parked) begin
                m_parked = 1'b0;
                m_pc = tgt;
            end else if (acc) begin
                m_orphan = 1'b0;
                m_pc = tgt;
            end else begin
                m_orphan = 1'b1;
                m_redirect = tgt;
            end
        end else if (m_parked) begin
            if (!st) begin
                m_instr = m_parked_word;
                m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_parked = 1'b0;
            end
        end else if (m_orphan) begin
            if (acc) begin
                m_orphan = 1'b0;
                m_pc = m_redirect;
            end
            if (!st) begin
                m_valid = 1'b0;
                m_instr = '0;
            end
        end else if (acc && st) begin
            m_parked = 1'b1;
            m_parked_word = word;
        end else if (acc) begin
            m_instr = word;
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_valid = 1'b0;
            m_instr = '0;
        end
        @(posedge clk);
        #1;
        check_eq("valid", 64'(o_valid), 64'(m_valid));
        check_eq("instr", 64'(o_instr), 64'(m_instr));
        check_eq("pc4", 64'(o_pc4), 64'(m_pc4));
    endtask

    initial begin
        model_reset();
        do_reset();

        // Zero-wait streaming from reset.
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        check_eq("p1_instr", 64'(o_instr), 64'h8);
        check_eq("p1_pc4", 64'(o_pc4), 64'hC);
        check_eq("p1_valid", 64'(o_valid), 64'h1);
        check_eq("p1_addr", 64'(o_addr), 64'hC);

        // Two-cycle stall at PC 0x10.
        step(0, 0, '0, 1);
        step(1, 0, '0, 1);
        check_eq("p2_hold", 64'(dut.r_state), 64'(HOLD));
        check_eq("p2_req", 64'(o_req), 64'h0);
        check_eq("p2_frozen", 64'(o_instr), 64'hC);
        step(1, 0, '0, 1);
        check_eq("p2_frozen2", 64'(o_pc4), 64'h10);
        step(0, 0, '0, 1);
        check_eq("p2_instr", 64'(o_instr), 64'h10);
        check_eq("p2_pc4", 64'(o_pc4), 64'h14);
        check_eq("p2_addr", 64'(o_addr), 64'h14);

        // Slow memory at PC 0x20.
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 0);
            check_eq("p3_addr", 64'(o_addr), 64'h20);
            check_eq("p3_req", 64'(o_req), 64'h1);
        end
        step(0, 0, '0, 1);
        check_eq("p3_instr", 64'(o_instr), 64'h20);
        check_eq("p3_pc4", 64'(o_pc4), 64'h24);
        check_eq("p3_valid", 64'(o_valid), 64'h1);

        // Branch while a fetch of 0x30 is outstanding.
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        step(0, 1, 32'h100, 0);
        check_eq("p4_valid", 64'(o_valid), 64'h0);
        check_eq("p4_drain", 64'(dut.r_state), 64'(DRAIN));
        check_eq("p4_addr", 64'(o_addr), 64'h30);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        check_eq("p4_discard", 64'(o_valid), 64'h0);
        check_eq("p4_target", 64'(o_addr), 64'h100);
        step(0, 0, '0, 1);
        check_eq("p4_first", 64'(o_instr), 64'h100);

        // Branch beats stall, branch beats accept, branch in HOLD, last-wins.
        step(1, 1, 32'h40, 1);
        check_eq("p5_br_stall", 64'(o_valid), 64'h0);
        step(0, 0, '0, 1);
        step(0, 1, 32'h80, 1);
        check_eq("p5_br_acc", 64'(o_valid), 64'h0);
        check_eq("p5_br_addr", 64'(o_addr), 64'h80);
        step(1, 0, '0, 1);
        step(1, 1, 32'h300, 0);
        check_eq("p5_br_hold", 64'(o_addr), 64'h300);
        step(0, 1, 32'h180, 0);
        step(0, 1, 32'h200, 0);
        step(0, 0, '0, 1);
        check_eq("p5_last_wins", 64'(o_addr), 64'h200);

        // PC+4 wrap, then reset in the middle of a drain.
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, '0, 1);
        check_eq("p6_wrap", 64'(o_pc4), 64'h0);
        check_eq("p6_wrap_addr", 64'(o_addr), 64'h0);
        step(0, 1, 32'h500, 0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit          st;
            bit          br;
            bit          rdy;
            logic [31:0] tgt;
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(st, br, tgt, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
